clk_rec_ctrl: RTL and testbench
===============================

CLK_REC_CTRL -- requirements
Module: clk_rec_ctrl

Interface
REQ-001 The block SHALL use parameter CLK_LEN, default 32, as the width of interval and period values.
REQ-002 The block SHALL use parameter ACQ_EDGES, default 16, as the number of consecutive non-updating edges needed to declare lock.
REQ-003 The block SHALL use parameter TRK_EDGES, default 16, as the number of consecutive non-updating edges in TRACK before the period relaxes by 1.
REQ-004 The block SHALL use parameter TOL, default 2, as the tolerance in clk_300M cycles below the period before a shorter interval forces re-acquisition.
REQ-005 The block SHALL use parameter RUN_SHIFT, default 5, so that silence beyond (period << RUN_SHIFT) cycles means loss of signal.
REQ-006 The block SHALL have port clk_300M, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port enable, input, 1 bit: high = run recovery, low = return to IDLE.
REQ-009 The block SHALL have port edge_pulse, input, 1 bit: one-cycle pulse marking a qualified data edge.
REQ-010 The block SHALL have port interval, input, CLK_LEN bits: cycles since the previous edge, valid only with edge_pulse.
REQ-011 The block SHALL have port period, output, CLK_LEN bits: current bit-period estimate in clk_300M cycles.
REQ-012 The block SHALL have port locked, output, 1 bit: high only in TRACK.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=0, ACQUIRE=1, TRACK=2, LOST=3.
REQ-014 The block SHALL have port phase_rst, output, 1 bit: one-cycle pulse, registered one cycle after an accepted edge in ACQUIRE or TRACK, used to realign the clock generator.
REQ-015 The block SHALL have port lost_pulse, output, 1 bit: one-cycle pulse on entry to LOST.

Function
REQ-016 In IDLE the block SHALL hold period at all-ones, locked low and the counters at 0; enable high SHALL move it to ACQUIRE on the next cycle.
REQ-017 In ACQUIRE, an edge_pulse with interval < period SHALL load period with interval and clear the stable counter; otherwise the edge SHALL increment the stable counter.
REQ-018 In ACQUIRE, an edge with no update while the stable counter equals ACQ_EDGES-1 SHALL move the block to TRACK with locked high on the next cycle.
REQ-019 In ACQUIRE, an interval of 0 SHALL be ignored and SHALL NOT count as an edge.
REQ-020 In TRACK, an edge with interval + TOL < period SHALL load period with interval, drop locked and return to ACQUIRE with the stable counter at 0.
REQ-021 In TRACK, every TRK_EDGES consecutive non-updating edges SHALL increment period by 1, saturating at all-ones, then clear the stable counter.
REQ-022 The silence counter SHALL clear on every edge_pulse, increment otherwise and saturate at all-ones.
REQ-023 The silence threshold (period << RUN_SHIFT) SHALL be computed at CLK_LEN+RUN_SHIFT bits, with no truncation.
REQ-024 In TRACK or ACQUIRE with period not all-ones, silence reaching the threshold SHALL move the block to LOST and pulse lost_pulse.
REQ-025 LOST SHALL last exactly one cycle, then go to ACQUIRE with period reset to all-ones and both counters cleared.
REQ-026 If edge_pulse and the silence timeout occur in the same cycle, the edge SHALL take priority and no LOST transition SHALL occur.
REQ-027 enable low in any state SHALL force IDLE on the next cycle; this overrides every edge and timeout event.
REQ-028 An edge_pulse in IDLE or LOST SHALL be ignored.
REQ-029 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-030 rst high SHALL, at the next clk_300M edge, force state=IDLE, period=all-ones, locked=0, phase_rst=0, lost_pulse=0, and all counters to 0.
REQ-031 rst high SHALL take priority over enable and edge_pulse, including a reset applied mid-acquisition or mid-track.

Verification
REQ-032 Bench scenario: enable=1, 17 edges with interval=100 -> period=100 after the first edge; TRACK with locked=1 after edge 17; phase_rst pulses once per edge.
REQ-033 Bench scenario: in TRACK at period=100, one edge with interval=97 -> period=97, state=ACQUIRE, locked=0 on the next cycle; an edge with interval=99 -> no change.
REQ-034 Bench scenario: in TRACK at period=100, 16 edges with interval=200 -> period=101.
REQ-035 Bench scenario: in TRACK at period=100, no edges for 3200 cycles -> lost_pulse for one cycle, then ACQUIRE with period=all-ones; an edge on cycle 3200 instead -> stays in TRACK.
REQ-036 Bench scenario: rst or enable=0 asserted during ACQUIRE after 5 edges -> IDLE with period=all-ones on the next cycle; edges are then ignored until enable=1.

Source files
------------

// File: rtl/clk_rec_ctrl.sv
// -----------------------------------------------------------------------------
// clk_rec_ctrl
// Bit-period acquisition and tracking controller for a data-driven clock
// recovery loop. It watches qualified data edges and their spacing, and it
// estimates the bit period in clk_300M cycles. It declares lock once the
// estimate has been stable for a number of edges. It also detects loss of
// signal when the line goes silent for too long.
//
// Ports
//   clk_300M    in   single clock, rising edge
//   rst         in   synchronous active-high reset
//   enable      in   1 = run recovery, 0 = return to IDLE
//   edge_pulse  in   one-cycle pulse marking a qualified data edge
//   interval    in   cycles since previous edge, valid with edge_pulse
//   period      out  current bit-period estimate (all-ones = unknown)
//   locked      out  high only in TRACK
//   state       out  IDLE=0, ACQUIRE=1, TRACK=2, LOST=3
//   phase_rst   out  one-cycle pulse the cycle after an accepted edge
//   lost_pulse  out  one-cycle pulse on entry to LOST
// -----------------------------------------------------------------------------
module clk_rec_ctrl #(
    parameter int unsigned CLK_LEN   = 32,
    parameter int unsigned ACQ_EDGES = 16,
    parameter int unsigned TRK_EDGES = 16,
    parameter int unsigned TOL       = 2,
    parameter int unsigned RUN_SHIFT = 5
) (
    input  logic               clk_300M,
    input  logic               rst,
    input  logic               enable,
    input  logic               edge_pulse,
    input  logic [CLK_LEN-1:0] interval,
    output logic [CLK_LEN-1:0] period,
    output logic               locked,
    output logic [1:0]         state,
    output logic               phase_rst,
    output logic               lost_pulse
);

    localparam int unsigned SIL_W   = CLK_LEN + RUN_SHIFT;
    localparam int unsigned CNT_MAX = (ACQ_EDGES > TRK_EDGES) ? ACQ_EDGES : TRK_EDGES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned CMP_W   = CLK_LEN + 1;

    localparam logic [CLK_LEN-1:0] PERIOD_MAX  = {CLK_LEN{1'b1}};
    localparam logic [SIL_W-1:0]   SILENCE_MAX = {SIL_W{1'b1}};
    localparam logic [CNT_W-1:0]   ACQ_LAST    = CNT_W'(ACQ_EDGES - 1);
    localparam logic [CNT_W-1:0]   TRK_LAST    = CNT_W'(TRK_EDGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2,
        ST_LOST  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CLK_LEN-1:0] period_q, period_d;
    logic [CNT_W-1:0]   stable_q, stable_d;
    logic [SIL_W-1:0]   silence_q, silence_d;
    logic               locked_q, locked_d;
    logic               phase_rst_q, phase_rst_d;
    logic               lost_pulse_q, lost_pulse_d;

    logic [SIL_W-1:0]   silence_thr;
    logic [SIL_W-1:0]   silence_inc;
    logic               timeout;
    logic               acq_shorter;
    logic               trk_shorter;
    logic [CLK_LEN-1:0] period_relaxed;

    // Event decode shared by the FSM
    always_comb begin
        // Threshold is kept at full width so large periods cannot wrap to a short timeout
        silence_thr    = SIL_W'(period_q) << RUN_SHIFT;
        silence_inc    = (silence_q == SILENCE_MAX) ? silence_q : silence_q + SIL_W'(1);
        // An edge in the same cycle always wins over the timeout
        timeout        = !edge_pulse && (period_q != PERIOD_MAX) && (silence_q >= silence_thr);
        acq_shorter    = interval < period_q;
        // One extra bit so interval + TOL cannot overflow
        trk_shorter    = (CMP_W'(interval) + CMP_W'(TOL)) < CMP_W'(period_q);
        period_relaxed = (period_q == PERIOD_MAX) ? period_q : period_q + CLK_LEN'(1);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        period_d     = period_q;
        stable_d     = stable_q;
        silence_d    = edge_pulse ? '0 : silence_inc;
        phase_rst_d  = 1'b0;
        lost_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                period_d  = PERIOD_MAX;
                stable_d  = '0;
                silence_d = '0;
                state_d   = ST_ACQ;
            end

            ST_ACQ: begin
                // Zero-length intervals are glitches, not edges
                if (edge_pulse && (interval != '0)) begin
                    phase_rst_d = 1'b1;
                    if (acq_shorter) begin
                        period_d = interval;
                        stable_d = '0;
                    end else if (stable_q == ACQ_LAST) begin
                        state_d  = ST_TRACK;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + CNT_W'(1);
                    end
                end else if (timeout) begin
                    state_d      = ST_LOST;
                    lost_pulse_d = 1'b1;
                end
            end

            ST_TRACK: begin
                if (edge_pulse) begin
                    phase_rst_d = 1'b1;
                    if (trk_shorter) begin
                        // Clearly shorter bit seen: estimate was too long, re-acquire
                        period_d = interval;
                        stable_d = '0;
                        state_d  = ST_ACQ;
                    end else if (stable_q == TRK_LAST) begin
                        // Slow upward relaxation lets the estimate follow a drifting rate
                        period_d = period_relaxed;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + CNT_W'(1);
                    end
                end else if (timeout) begin
                    state_d      = ST_LOST;
                    lost_pulse_d = 1'b1;
                end
            end

            ST_LOST: begin
                state_d   = ST_ACQ;
                period_d  = PERIOD_MAX;
                stable_d  = '0;
                silence_d = '0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Disable overrides every edge and timeout event
        if (!enable) begin
            state_d      = ST_IDLE;
            period_d     = PERIOD_MAX;
            stable_d     = '0;
            silence_d    = '0;
            phase_rst_d  = 1'b0;
            lost_pulse_d = 1'b0;
        end

        locked_d = (state_d == ST_TRACK);
    end

    // State and output registers
    always_ff @(posedge clk_300M) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            period_q     <= PERIOD_MAX;
            stable_q     <= '0;
            silence_q    <= '0;
            locked_q     <= 1'b0;
            phase_rst_q  <= 1'b0;
            lost_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            stable_q     <= stable_d;
            silence_q    <= silence_d;
            locked_q     <= locked_d;
            phase_rst_q  <= phase_rst_d;
            lost_pulse_q <= lost_pulse_d;
        end
    end

    assign period     = period_q;
    assign locked     = locked_q;
    assign state      = state_q;
    assign phase_rst  = phase_rst_q;
    assign lost_pulse = lost_pulse_q;

endmodule

// File: tb/tb_clk_rec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_rec_ctrl
// Directed bench for clk_rec_ctrl with default parameters. Inputs change just
// after a rising edge; outputs are checked 1 ns after the rising edge that
// sampled them.
// -----------------------------------------------------------------------------
module tb_clk_rec_ctrl;

    localparam logic [31:0] ONES   = 32'hFFFF_FFFF;
    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_ACQ  = 2'd1;
    localparam logic [1:0]  S_TRK  = 2'd2;
    localparam logic [1:0]  S_LOST = 2'd3;

    logic        clk_300M = 1'b0;
    logic        rst;
    logic        enable;
    logic        edge_pulse;
    logic [31:0] interval;
    logic [31:0] period;
    logic        locked;
    logic [1:0]  state;
    logic        phase_rst;
    logic        lost_pulse;

    int checks   = 0;
    int failures = 0;

    clk_rec_ctrl dut (
        .clk_300M   (clk_300M),
        .rst        (rst),
        .enable     (enable),
        .edge_pulse (edge_pulse),
        .interval   (interval),
        .period     (period),
        .locked     (locked),
        .state      (state),
        .phase_rst  (phase_rst),
        .lost_pulse (lost_pulse)
    );

    always #5 clk_300M = ~clk_300M;

    task automatic tick();
        @(posedge clk_300M);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_edge(input logic [31:0] iv);
        edge_pulse = 1'b1;
        interval   = iv;
        tick();
        edge_pulse = 1'b0;
        interval   = '0;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        enable     = 1'b0;
        edge_pulse = 1'b0;
        interval   = '0;
        tick();
        rst = 1'b0;
    endtask

    // Reset, enable and feed 17 edges of 100 cycles: ends in TRACK at period 100
    task automatic lock_at_100();
        do_reset();
        enable = 1'b1;
        tick();
        chk("acq_entry_state", 64'(state), 64'(S_ACQ));
        for (int i = 1; i <= 17; i++) begin
            send_edge(32'd100);
            chk("lock_phase_rst_hi", 64'(phase_rst), 64'd1);
            chk("lock_period", 64'(period), 64'd100);
            if (i < 17) begin
                chk("lock_state_acq", 64'(state), 64'(S_ACQ));
                chk("lock_locked_lo", 64'(locked), 64'd0);
            end else begin
                chk("lock_state_trk", 64'(state), 64'(S_TRK));
                chk("lock_locked_hi", 64'(locked), 64'd1);
            end
            tick();
            chk("lock_phase_rst_lo", 64'(phase_rst), 64'd0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        enable     = 1'b0;
        edge_pulse = 1'b0;
        interval   = '0;
        tick();
        tick();

        // Reset values
        chk("rst_state", 64'(state), 64'(S_IDLE));
        chk("rst_period", 64'(period), 64'(ONES));
        chk("rst_locked", 64'(locked), 64'd0);
        chk("rst_phase_rst", 64'(phase_rst), 64'd0);
        chk("rst_lost_pulse", 64'(lost_pulse), 64'd0);

        // Edge in IDLE ignored
        rst = 1'b0;
        send_edge(32'd50);
        chk("idle_edge_state", 64'(state), 64'(S_IDLE));
        chk("idle_edge_period", 64'(period), 64'(ONES));
        chk("idle_edge_phase", 64'(phase_rst), 64'd0);

        // Acquire and lock at 100
        lock_at_100();

        // Relaxation: 16 long intervals raise the period by one
        for (int i = 1; i <= 16; i++) begin
            send_edge(32'd200);
            if (i < 16) chk("relax_hold", 64'(period), 64'd100);
            else        chk("relax_step", 64'(period), 64'd101);
            chk("relax_state", 64'(state), 64'(S_TRK));
            tick();
        end

        // Within tolerance: no change; beyond tolerance: back to ACQUIRE
        lock_at_100();
        send_edge(32'd99);
        chk("tol99_period", 64'(period), 64'd100);
        chk("tol99_state", 64'(state), 64'(S_TRK));
        chk("tol99_locked", 64'(locked), 64'd1);
        tick();
        send_edge(32'd97);
        chk("short97_period", 64'(period), 64'd97);
        chk("short97_state", 64'(state), 64'(S_ACQ));
        chk("short97_locked", 64'(locked), 64'd0);
        chk("short97_phase", 64'(phase_rst), 64'd1);
        tick();

        // Silence timeout: threshold 100<<5 = 3200
        lock_at_100();
        for (int i = 0; i < 3199; i++) tick();
        chk("sil_pre_state", 64'(state), 64'(S_TRK));
        chk("sil_pre_lost", 64'(lost_pulse), 64'd0);
        tick();
        chk("sil_lost_state", 64'(state), 64'(S_LOST));
        chk("sil_lost_pulse", 64'(lost_pulse), 64'd1);
        chk("sil_lost_locked", 64'(locked), 64'd0);
        tick();
        chk("sil_acq_state", 64'(state), 64'(S_ACQ));
        chk("sil_acq_period", 64'(period), 64'(ONES));
        chk("sil_acq_lost_lo", 64'(lost_pulse), 64'd0);

        // Edge coinciding with the timeout cycle wins
        lock_at_100();
        for (int i = 0; i < 3199; i++) tick();
        send_edge(32'd3201);
        chk("sil_edge_state", 64'(state), 64'(S_TRK));
        chk("sil_edge_lost", 64'(lost_pulse), 64'd0);
        chk("sil_edge_phase", 64'(phase_rst), 64'd1);
        for (int i = 0; i < 20; i++) tick();
        chk("sil_edge_stay", 64'(state), 64'(S_TRK));
        chk("sil_edge_period", 64'(period), 64'd100);

        // Reset mid-acquisition, with enable and edge asserted
        do_reset();
        enable = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            send_edge(32'd100);
            tick();
        end
        chk("acq5_period", 64'(period), 64'd100);
        send_edge(32'd0);
        chk("zero_iv_phase", 64'(phase_rst), 64'd0);
        chk("zero_iv_period", 64'(period), 64'd100);
        chk("zero_iv_state", 64'(state), 64'(S_ACQ));
        rst = 1'b1;
        send_edge(32'd50);
        rst = 1'b0;
        chk("midrst_state", 64'(state), 64'(S_IDLE));
        chk("midrst_period", 64'(period), 64'(ONES));
        chk("midrst_phase", 64'(phase_rst), 64'd0);
        enable = 1'b0;
        send_edge(32'd40);
        chk("post_rst_edge_state", 64'(state), 64'(S_IDLE));
        chk("post_rst_edge_period", 64'(period), 64'(ONES));

        // Disable mid-acquisition overrides a simultaneous edge
        enable = 1'b1;
        tick();
        chk("reen_state", 64'(state), 64'(S_ACQ));
        for (int i = 0; i < 5; i++) begin
            send_edge(32'd100);
            tick();
        end
        enable = 1'b0;
        send_edge(32'd50);
        chk("dis_state", 64'(state), 64'(S_IDLE));
        chk("dis_period", 64'(period), 64'(ONES));
        chk("dis_phase", 64'(phase_rst), 64'd0);
        send_edge(32'd30);
        chk("dis_edge_state", 64'(state), 64'(S_IDLE));
        chk("dis_edge_period", 64'(period), 64'(ONES));
        enable = 1'b1;
        tick();
        chk("reen2_state", 64'(state), 64'(S_ACQ));
        send_edge(32'd60);
        chk("reen2_period", 64'(period), 64'd60);
        chk("reen2_phase", 64'(phase_rst), 64'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
